// File: rtl/jcs_alu_seq.sv
// jcs_alu_seq: sequential ALU with a saturating op-code selector.
// An op is captured on START (IDLE or FIN only) and completes via EXEC (one
// edge) or SHIFT (one edge per bit). Y and flags update only on completion.
// Ports:
//   CLK, RSTN         clock, async active-low reset
//   MODE_UP, MODE_DN  single-cycle pulses stepping the selected op code
//   START             request execution of the selected op
//   A, B, CI, SHAMT   operands, carry/shift-in bit, shift distance
//   OP                currently selected op code
//   BUSY, DONE        op in flight / one-cycle completion pulse
//   Y, CO, AL, EQ, Z  registered result, carry-out, A>B, A==B, zero
module jcs_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             MODE_UP,
    input  logic             MODE_DN,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic [SW-1:0]    SHAMT,
    output logic [2:0]       OP,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             AL,
    output logic             EQ,
    output logic             Z
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_FIN} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_sel_q, op_sel_d;
    logic [2:0]         opx_q, opx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               ci_q, ci_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               co_q, co_d, al_q, al_d, eq_q, eq_d, z_q, z_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               accept_c, shift_path_c, last_c, step_out_c, res_co_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   step_c, res_c;

    // START only lands when no op is in flight
    assign accept_c     = START && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign shift_path_c = ((op_sel_q == OP_SHR) || (op_sel_q == OP_SHL)) && (SHAMT != '0);
    assign last_c       = (cnt_q == SW'(1));
    assign sum_c        = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(ci_q);

    // Saturating op-code selector; simultaneous up/down cancels
    always_comb begin
        op_sel_d = op_sel_q;
        if (MODE_UP && !MODE_DN && (op_sel_q != OP_CMP)) begin
            op_sel_d = op_sel_q + 3'd1;
        end else if (MODE_DN && !MODE_UP && (op_sel_q != OP_ADD)) begin
            op_sel_d = op_sel_q - 3'd1;
        end
    end

    // One-bit shift step of the working register
    always_comb begin
        if (opx_q == OP_SHR) begin
            step_c     = {ci_q, work_q[WIDTH-1:1]};
            step_out_c = work_q[0];
        end else begin
            step_c     = {work_q[WIDTH-2:0], ci_q};
            step_out_c = work_q[WIDTH-1];
        end
    end

    // Single-edge result; shifts only reach here with a zero distance
    always_comb begin
        res_c    = '0;
        res_co_c = 1'b0;
        case (opx_q)
            OP_ADD: begin
                res_c    = sum_c[WIDTH-1:0];
                res_co_c = sum_c[WIDTH];
            end
            OP_SHR, OP_SHL: res_c = a_q;
            OP_NOT:         res_c = ~a_q;
            OP_AND:         res_c = a_q & b_q;
            OP_OR:          res_c = a_q | b_q;
            OP_XOR:         res_c = a_q ^ b_q;
            default:        res_c = a_q ^ b_q;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = shift_path_c ? S_SHIFT : S_EXEC;
            S_EXEC:  state_d = S_FIN;
            S_SHIFT: if (last_c) state_d = S_FIN;
            S_FIN:   state_d = accept_c ? (shift_path_c ? S_SHIFT : S_EXEC) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and status outputs
    always_comb begin
        opx_d  = opx_q;
        a_d    = a_q;
        b_d    = b_q;
        ci_d   = ci_q;
        cnt_d  = cnt_q;
        work_d = work_q;
        y_d    = y_q;
        co_d   = co_q;
        al_d   = al_q;
        eq_d   = eq_q;
        z_d    = z_q;
        busy_d = (state_d == S_EXEC) || (state_d == S_SHIFT);
        done_d = (state_d == S_FIN);

        if (accept_c) begin
            opx_d  = op_sel_q;
            a_d    = A;
            b_d    = B;
            ci_d   = CI;
            cnt_d  = SHAMT;
            work_d = A;
        end

        case (state_q)
            S_EXEC: begin
                // CMP leaves Y alone and only reports flags of A^B
                if (opx_q != OP_CMP) y_d = res_c;
                co_d = res_co_c;
                al_d = (a_q > b_q);
                eq_d = (a_q == b_q);
                z_d  = (res_c == '0);
            end
            S_SHIFT: begin
                work_d = step_c;
                cnt_d  = cnt_q - SW'(1);
                if (last_c) begin
                    y_d  = step_c;
                    co_d = step_out_c;
                    al_d = (a_q > b_q);
                    eq_d = (a_q == b_q);
                    z_d  = (step_c == '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            op_sel_q <= OP_ADD;
            opx_q    <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            ci_q     <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            y_q      <= '0;
            co_q     <= 1'b0;
            al_q     <= 1'b0;
            eq_q     <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_sel_q <= op_sel_d;
            opx_q    <= opx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ci_q     <= ci_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            y_q      <= y_d;
            co_q     <= co_d;
            al_q     <= al_d;
            eq_q     <= eq_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign OP   = op_sel_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Y    = y_q;
    assign CO   = co_q;
    assign AL   = al_q;
    assign EQ   = eq_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_jcs_alu_seq.sv
// tb_jcs_alu_seq: randomized and directed stimulus for jcs_alu_seq (WIDTH=8)
// with a result scoreboard drained by an independent DONE monitor.
module tb_jcs_alu_seq;

    typedef struct packed {
        logic [7:0] y;
        logic       co;
        logic       al;
        logic       eq;
        logic       z;
    } res_t;

    logic       CLK, RSTN, MODE_UP, MODE_DN, START, CI;
    logic [7:0] A, B, Y;
    logic [2:0] SHAMT, OP;
    logic       BUSY, DONE, CO, AL, EQ, Z;

    res_t       exp_q[$];
    res_t       cur;
    res_t       m_exp, m_act, dexp;
    int         tb_op;
    int         checks;
    int         failures;
    logic [7:0] r_a, r_b;
    logic       r_ci;
    logic [2:0] r_sh;

    jcs_alu_seq dut (
        .CLK(CLK), .RSTN(RSTN), .MODE_UP(MODE_UP), .MODE_DN(MODE_DN),
        .START(START), .A(A), .B(B), .CI(CI), .SHAMT(SHAMT),
        .OP(OP), .BUSY(BUSY), .DONE(DONE), .Y(Y),
        .CO(CO), .AL(AL), .EQ(EQ), .Z(Z)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                checks++;
                m_act = {Y, CO, AL, EQ, Z};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done actual={Y=%02h CO=%b AL=%b EQ=%b Z=%b} required=no DONE",
                             Y, CO, AL, EQ, Z);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_act !== m_exp) begin
                        failures++;
                        $display("FAIL sb_result actual={Y=%02h CO=%b AL=%b EQ=%b Z=%b} required={Y=%02h CO=%b AL=%b EQ=%b Z=%b}",
                                 m_act.y, m_act.co, m_act.al, m_act.eq, m_act.z,
                                 m_exp.y, m_exp.co, m_exp.al, m_exp.eq, m_exp.z);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: whole-operation arithmetic, shifts computed in one step
    function automatic res_t ref_op(input int op, input int a, input int b, input int ci,
                                    input int sh, input logic [7:0] prev_y);
        int   r;
        int   co;
        res_t o;
        r  = 0;
        co = 0;
        case (op)
            0: begin
                r  = a + b + ci;
                co = (r >> 8) & 1;
                r  = r & 255;
            end
            1: begin
                if (sh == 0) r = a;
                else begin
                    r  = (a >> sh) | ((ci != 0) ? ((255 << (8 - sh)) & 255) : 0);
                    co = (a >> (sh - 1)) & 1;
                end
            end
            2: begin
                if (sh == 0) r = a;
                else begin
                    r  = ((a << sh) | ((ci != 0) ? ((1 << sh) - 1) : 0)) & 255;
                    co = (a >> (8 - sh)) & 1;
                end
            end
            3: r = (~a) & 255;
            4: r = a & b;
            5: r = a | b;
            default: r = a ^ b;
        endcase
        o.y  = (op == 7) ? prev_y : 8'(r);
        o.co = (co != 0);
        o.al = (a > b);
        o.eq = (a == b);
        o.z  = (r == 0);
        return o;
    endfunction

    task automatic mode_pulse(input logic up, input logic dn);
        MODE_UP = up;
        MODE_DN = dn;
        tick();
        MODE_UP = 1'b0;
        MODE_DN = 1'b0;
        if (up && !dn && tb_op < 7) tb_op++;
        else if (dn && !up && tb_op > 0) tb_op--;
        chk("op_select", 32'(OP), 32'(tb_op));
        tick();
    endtask

    task automatic set_op(input int target);
        while (tb_op < target) mode_pulse(1'b1, 1'b0);
        while (tb_op > target) mode_pulse(1'b0, 1'b1);
    endtask

    task automatic hold_chk();
        chk("hold_outputs", 32'({Y, CO, AL, EQ, Z}), 32'(cur));
    endtask

    // Issue one op; chg steps OP while busy, ign pulses a START that must be dropped
    task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                            input logic [2:0] sh, input bit dir, input res_t dx,
                            input bit chg, input bit ign);
        res_t e;
        int   op_c, lat, busy_n, exp_lat;
        hold_chk();
        op_c = tb_op;
        e = dir ? dx : ref_op(op_c, int'(a), int'(b), int'(ci), int'(sh), cur.y);
        A = a; B = b; CI = ci; SHAMT = sh; START = 1'b1;
        exp_q.push_back(e);
        tick();
        START = 1'b0;
        lat = 0;
        busy_n = 0;
        if (chg) MODE_UP = 1'b1;
        while (DONE !== 1'b1 && lat < 64) begin
            if (BUSY === 1'b1) busy_n++;
            if (ign && lat == 0) begin
                START = 1'b1;
                A = ~a;
            end
            tick();
            MODE_UP = 1'b0;
            START = 1'b0;
            lat++;
        end
        if (chg && tb_op < 7) tb_op++;
        exp_lat = ((op_c == 1 || op_c == 2) && sh != 3'd0) ? int'(sh) : 1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
        cur = e;
        tick();
        chk("done_one_cycle", 32'(DONE), 32'(0));
        chk("busy_after_done", 32'(BUSY), 32'(0));
        if (chg) chk("op_after_change", 32'(OP), 32'(tb_op));
    endtask

    initial begin
        checks = 0; failures = 0; tb_op = 0; cur = '0;
        RSTN = 1'b0; MODE_UP = 1'b0; MODE_DN = 1'b0; START = 1'b0;
        A = '0; B = '0; CI = 1'b0; SHAMT = '0;
        repeat (3) tick();
        chk("reset_op", 32'(OP), 32'(0));
        chk("reset_y_flags", 32'({Y, CO, AL, EQ, Z}), 32'(0));
        chk("reset_busy_done", 32'({BUSY, DONE}), 32'(0));
        @(negedge CLK);
        RSTN = 1'b1;
        tick();

        // Selector saturation
        repeat (8) mode_pulse(1'b1, 1'b0);
        chk("op_sat_up", 32'(OP), 32'(7));
        mode_pulse(1'b1, 1'b1);
        chk("op_both_pulses", 32'(OP), 32'(7));
        repeat (8) mode_pulse(1'b0, 1'b1);
        chk("op_sat_dn", 32'(OP), 32'(0));

        // ADD overflow
        dexp = '{y: 8'h00, co: 1'b1, al: 1'b1, eq: 1'b0, z: 1'b1};
        issue_op(8'hFF, 8'h01, 1'b0, 3'd0, 1'b1, dexp, 1'b0, 1'b0);

        // SHL by 3 with CI=1, plus an ignored START while busy
        set_op(2);
        dexp = '{y: 8'h0F, co: 1'b0, al: 1'b1, eq: 1'b0, z: 1'b0};
        issue_op(8'h81, 8'h00, 1'b1, 3'd3, 1'b1, dexp, 1'b0, 1'b1);

        // CMP keeps Y
        set_op(7);
        dexp = '{y: 8'h0F, co: 1'b0, al: 1'b0, eq: 1'b1, z: 1'b1};
        issue_op(8'h10, 8'h10, 1'b0, 3'd0, 1'b1, dexp, 1'b0, 1'b0);

        // SHR by 0, START held through FIN for a back-to-back op
        set_op(1);
        hold_chk();
        A = 8'h01; B = 8'h00; CI = 1'b1; SHAMT = 3'd0; START = 1'b1;
        dexp = '{y: 8'h01, co: 1'b0, al: 1'b1, eq: 1'b0, z: 1'b0};
        exp_q.push_back(dexp);
        tick();
        A = 8'h80; B = 8'h80; CI = 1'b0;
        tick();
        chk("b2b_first_done", 32'(DONE), 32'(1));
        dexp = '{y: 8'h80, co: 1'b0, al: 1'b0, eq: 1'b1, z: 1'b0};
        exp_q.push_back(dexp);
        tick();
        START = 1'b0;
        chk("b2b_no_idle_gap", 32'({BUSY, DONE}), 32'(2));
        tick();
        chk("b2b_second_done", 32'(DONE), 32'(1));
        cur = dexp;
        tick();
        chk("b2b_done_drop", 32'(DONE), 32'(0));

        // Randomized ops against the reference
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) mode_pulse(1'b1, 1'b1);
            set_op(int'($urandom_range(0, 7)));
            r_a  = 8'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : 8'($urandom);
            r_ci = 1'($urandom);
            r_sh = 3'($urandom);
            issue_op(r_a, r_b, r_ci, r_sh, 1'b0, '0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        // Reset in the third SHIFT cycle of SHR by 7
        set_op(1);
        hold_chk();
        A = 8'h5A; B = 8'h33; CI = 1'b1; SHAMT = 3'd7; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        START = 1'b1;
        A = 8'hFF;
        tick();
        START = 1'b0;
        chk("busy_before_reset", 32'(BUSY), 32'(1));
        RSTN = 1'b0;
        #1;
        chk("rst_mid_op", 32'(OP), 32'(0));
        chk("rst_mid_y_flags", 32'({Y, CO, AL, EQ, Z}), 32'(0));
        chk("rst_mid_busy_done", 32'({BUSY, DONE}), 32'(0));
        tb_op = 0;
        cur = '0;
        @(negedge CLK);
        RSTN = 1'b1;
        r_a = 8'($urandom);
        r_b = 8'($urandom);
        issue_op(r_a, r_b, 1'b1, 3'd0, 1'b0, '0, 1'b0, 1'b0);
        repeat (12) tick();
        hold_chk();

        for (int i = 0; i < 15; i++) begin
            set_op(int'($urandom_range(0, 7)));
            r_a  = 8'($urandom);
            r_b  = ($urandom_range(0, 2) == 0) ? r_a : 8'($urandom);
            r_ci = 1'($urandom);
            r_sh = 3'($urandom);
            issue_op(r_a, r_b, r_ci, r_sh, 1'b0, '0, 1'b0, $urandom_range(0, 1) == 1);
        end

        repeat (5) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jcs_alu_seq.md
JCS_ALU_SEQ -- requirements
Module: jcs_alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 2..32.
REQ-002 Parameter SW, default $clog2(WIDTH), width of the shift-amount port.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 MODE_UP  input  1  single-cycle pulse (already debounced): select next op code.
REQ-006 MODE_DN  input  1  single-cycle pulse (already debounced): select previous op code.
REQ-007 START  input  1  request execution of the currently selected op.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 CI  input  1  carry-in / shift-in bit.
REQ-011 SHAMT  input  SW  shift distance for SHR/SHL.
REQ-012 OP  output  3  currently selected op code.
REQ-013 BUSY  output  1  high while an operation is in flight.
REQ-014 DONE  output  1  one-cycle pulse when Y and flags have been updated.
REQ-015 Y  output  WIDTH  registered result.
REQ-016 CO, AL, EQ, Z  output  1 each  registered carry-out, A-larger, A-equal-B, zero flags.

Function
REQ-017 Op codes: ADD=0, SHR=1, SHL=2, NOT=3, AND=4, OR=5, XOR=6, CMP=7.
REQ-018 OP increments on MODE_UP and decrements on MODE_DN, saturating at 0 and 7; both asserted in the same cycle -> no change.
REQ-019 OP changes at any time, including while BUSY; an in-flight operation always uses the op code captured at START.
REQ-020 State machine: IDLE, EXEC, SHIFT, FIN.
REQ-021 START is accepted only in IDLE or FIN; when accepted, A, B, CI, OP are captured and a counter is loaded from SHAMT.
REQ-022 Capture -> SHIFT if captured op is SHR/SHL and SHAMT>0; otherwise -> EXEC.
REQ-023 EXEC: next edge writes Y and flags, goes to FIN; total latency 2 edges from START-sampling edge to DONE high.
REQ-024 SHIFT: each edge shifts the working register by one bit and decrements the counter; the edge on which the counter reaches 0 writes Y and flags and goes to FIN; latency SHAMT+1 edges.
REQ-025 FIN: DONE=1 for exactly this one cycle; next state is IDLE, or the capture path if START is high.
REQ-026 BUSY=1 in EXEC and SHIFT, 0 in IDLE and FIN; START while BUSY is ignored (not queued).
REQ-027 ADD: {CO,Y} = A + B + CI, (WIDTH+1)-bit sum.
REQ-028 SHR: per step, CI enters the MSB and the LSB leaves; SHL: CI enters the LSB and the MSB leaves; CO = last bit shifted out; SHAMT=0 -> Y=A, CO=0.
REQ-029 NOT: Y=~A; AND/OR/XOR: Y = A op B; CO=0 for NOT, AND, OR, XOR, CMP.
REQ-030 CMP: Y retains its previous value; only flags are updated, with the compare result taken as A^B.
REQ-031 For every op, EQ=(A==B) and AL=(A>B) unsigned on the captured operands; Z=(result==0), where result is the new Y (A^B for CMP).
REQ-032 Y and flags hold their values between operations and change only on a completing edge.

Reset
REQ-033 RSTN low immediately forces: state=IDLE, OP=ADD, Y=0, CO=AL=EQ=Z=0, BUSY=0, DONE=0, counter=0.
REQ-034 Reset mid-operation aborts it: no DONE is issued and no Y/flag update occurs after release; the first edge after release samples START normally.

Verification (WIDTH=8)
REQ-035 OP=ADD, A=0xFF, B=0x01, CI=0, START -> DONE 2 edges later; Y=0x00, CO=1, Z=1, EQ=0, AL=1.
REQ-036 OP=SHL, A=0x81, CI=1, SHAMT=3, START -> BUSY high for 3 cycles, DONE on edge 4; Y=0x0F, CO=0.
REQ-037 From reset, 8 MODE_UP pulses -> OP=7 (saturated); MODE_UP and MODE_DN in the same cycle -> OP unchanged; 8 MODE_DN pulses -> OP=0.
REQ-038 With Y=0x0F, OP=CMP, A=B=0x10, START -> Y stays 0x0F; EQ=1, AL=0, Z=1, CO=0.
REQ-039 OP=SHR, SHAMT=7, START, then RSTN low on the 3rd SHIFT cycle -> all outputs 0 immediately; no DONE after release; a START issued while BUSY is ignored.
REQ-040 OP=SHR, A=0x01, SHAMT=0, START -> latency 2; Y=0x01, CO=0; a START held high in FIN starts a back-to-back operation with no IDLE gap.
